prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that fills the CPU's 32×8 instruction/data memory and holds the CPU in reset until a complete, checksum-valid image has been written. It takes framed bytes from a host on a valid/ready stream and drives the memory write side. Its `cpu_rst_` output gates the CPU's `rst_`.

## Interface
Parameters:
- `AWIDTH`, 5: memory address width. Depth is 2^AWIDTH.
- `DWIDTH`, 8: memory word and stream byte width.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst_`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: host byte valid.
- `in_data`, in, DWIDTH: host byte.
- `in_ready`, out, 1: loader can accept a byte. Equals 1 whenever `rst_` is high.
- `mem_addr`, out, AWIDTH: write address to memory.
- `mem_data`, out, DWIDTH: write data to memory.
- `mem_write`, out, 1: one-cycle write strobe.
- `cpu_rst_`, out, 1: active-low CPU reset; low = CPU held.
- `busy`, out, 1: a frame is in progress.
- `done`, out, 1: one-cycle pulse when a frame completes with a good checksum.
- `err`, out, 1: sticky frame error.

## Operation
- Frame format: `SYNC` (8'hA5), `ADDR`, `COUNT`, `COUNT` data bytes, `CSUM`.
- A byte is accepted on a posedge where `in_valid && in_ready`. When `in_valid` is low, the state holds.
- FSM states: IDLE, ADDR, COUNT, DATA, CSUM, ERR.
- IDLE: a byte equal to SYNC goes to ADDR. Any other byte is dropped silently.
- ADDR: if bits [7:AWIDTH] are not all 0, go to ERR. Otherwise latch the write pointer, `sum = in_data`, and go to COUNT.
- COUNT: if the value is 0 or greater than 2^AWIDTH, go to ERR. Otherwise latch the remaining count, add the byte to `sum`, and go to DATA.
- DATA: for each byte, register `mem_addr` = pointer, `mem_data` = byte, and `mem_write` = 1. Then increment the pointer modulo 2^AWIDTH (wraps 31→0), add the byte to `sum`, and decrement the remaining count. After the last byte, go to CSUM.
- Inside DATA, a byte equal to 8'hA5 is data, not a resync.
- CSUM: if `(sum + in_data) mod 256 == 0`, pulse `done`, set `cpu_rst_` = 1, and go to IDLE. Otherwise set `err` and go to ERR.
- ERR: `err` = 1 and `cpu_rst_` = 0. Non-SYNC bytes are dropped. A SYNC byte clears `err` and goes to ADDR.
- Accepting SYNC in IDLE while `cpu_rst_` = 1 (a reload) drives `cpu_rst_` to 0, so the CPU is held for the whole new frame.
- Bytes written before a checksum failure stay in memory. The CPU stays held, so it never runs a partial image.
- `busy` = 1 in ADDR, COUNT, DATA and CSUM.

## Timing
- Reset values: `cpu_rst_` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_data` = 0, `done` = 0, `err` = 0, `busy` = 0, state IDLE. Reset applies immediately (asynchronous).
- All outputs are registered except `in_ready`.
- `mem_write` asserts in the cycle after a DATA byte is accepted. `mem_addr` and `mem_data` are stable for that whole cycle, so memory clocked on `~clk` samples them mid-cycle.
- Back-to-back DATA bytes give one write per cycle, so `mem_write` can stay high for consecutive cycles.
- `done` and `cpu_rst_` rise in the cycle after the CSUM byte is accepted. The last `mem_write` is already complete by then.
- `err` rises in the cycle after the offending byte is accepted. It falls in the cycle after SYNC is accepted in ERR.
- `cpu_rst_` falls in the cycle after SYNC is accepted in IDLE.
- Reset asserted mid-frame: the frame is abandoned, with no further `mem_write`. After reset, bytes are ignored until the next SYNC.

## Structure
- Add `loader_state_t` (IDLE, ADDR, COUNT, DATA, CSUM, ERR) and `LOADER_SYNC` = 8'hA5 to the shared `typedefs` package, alongside `opcode_t`.
- Single module, no sub-modules. FSM, pointer, remaining count and 8-bit sum are all local.
- At the CPU top level, `cpu_rst_` is ANDed with the system `rst_`. The loader's memory port is muxed with the CPU's port, with the loader selected while `cpu_rst_` = 0.

## Test plan
- Basic load: send A5, 00, 03, A2, 3F, 00, 1C.
  - Writes (0,A2), (1,3F), (2,00) appear on consecutive cycles.
  - One `done` pulse, then `cpu_rst_` = 1 and `err` = 0.
- Wrap-around: send A5, 1E, 04, 11, 22, 33, 44, 34.
  - Writes go to addresses 1E, 1F, 00, 01.
  - `done` pulses.
- Bad checksum: the basic frame with CSUM = 1D.
  - The three writes occur.
  - `err` = 1, no `done`, `cpu_rst_` stays 0.
  - A following good frame clears `err` and releases `cpu_rst_`.
- Bad header: send A5, 00, 00 (count 0), then separately A5, 20, ….
  - Each frame sets `err` after the second bad byte, with no `mem_write`.
  - The next A5 clears `err`.
- Reload and data-SYNC: after a good load, send A5. `cpu_rst_` drops one cycle later.
  - Then send 00, 02, A5, A5, B6 with `in_valid` gapped every other cycle.
  - Both A5 bytes are written as data and `done` pulses.
- Reset mid-frame: assert `rst_` after the second DATA byte.
  - Outputs are at reset values immediately, with no third write.
  - The remaining bytes are ignored until the next A5.

Source files
------------

// File: rtl/typedefs_pkg.sv
// Shared CPU-wide types: instruction opcodes and program loader states.
package typedefs;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_LD,
        OP_ST,
        OP_JMP,
        OP_BRZ
    } opcode_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_ADDR,
        L_COUNT,
        L_DATA,
        L_CSUM,
        L_ERR
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes the image into memory and holds the CPU
// in reset until a checksum-valid frame has completed.
module prog_loader
    import typedefs::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic              mem_write,
    output logic              cpu_rst_,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [DWIDTH-1:0] DEPTH = DWIDTH'(2 ** AWIDTH);
    localparam logic [AWIDTH:0]   LAST  = (AWIDTH + 1)'(1);

    loader_state_t     state_q;
    logic [AWIDTH-1:0] ptr_q;
    logic [AWIDTH:0]   rem_q;
    logic [DWIDTH-1:0] sum_q;
    logic [DWIDTH-1:0] sum_d;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;
    logic              wr_q;
    logic              cpu_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              is_sync;

    assign in_ready  = rst_;
    assign sum_d     = sum_q + in_data;
    assign is_sync   = (in_data == DWIDTH'(LOADER_SYNC));
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign mem_write = wr_q;
    assign cpu_rst_  = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= L_IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            sum_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            if (in_valid) begin
                unique case (state_q)
                    L_IDLE: begin
                        if (is_sync) begin
                            state_q   <= L_ADDR;
                            busy_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end
                    end
                    L_ADDR: begin
                        if (|in_data[DWIDTH-1:AWIDTH]) begin
                            state_q <= L_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            ptr_q   <= in_data[AWIDTH-1:0];
                            sum_q   <= in_data;
                            state_q <= L_COUNT;
                        end
                    end
                    L_COUNT: begin
                        if (in_data == '0 || in_data > DEPTH) begin
                            state_q <= L_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            rem_q   <= in_data[AWIDTH:0];
                            sum_q   <= sum_d;
                            state_q <= L_DATA;
                        end
                    end
                    // SYNC-valued bytes here are plain data
                    L_DATA: begin
                        addr_q <= ptr_q;
                        data_q <= in_data;
                        wr_q   <= 1'b1;
                        ptr_q  <= ptr_q + 1'b1;
                        sum_q  <= sum_d;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == LAST) begin
                            state_q <= L_CSUM;
                        end
                    end
                    L_CSUM: begin
                        busy_q <= 1'b0;
                        if (sum_d == '0) begin
                            state_q   <= L_IDLE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b1;
                        end else begin
                            state_q <= L_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    L_ERR: begin
                        if (is_sync) begin
                            state_q <= L_ADDR;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= L_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued as bytes are
// driven and popped when the loader strobes mem_write.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_write;
    logic       cpu_rst_;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];
    int wcyc[$];

    prog_loader #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk),
        .rst_(rst_),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_write(mem_write),
        .cpu_rst_(cpu_rst_),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (mem_write === 1'b1) begin
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("wr", {16'h0, 3'b0, mem_addr, mem_data},
                    {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] n,
                         input logic [7:0] d[], input bit bad_sum,
                         input bit sync, input int gap);
        logic [7:0] s;
        logic [4:0] p;
        s = a + n;
        p = a[4:0];
        if (sync) send(8'hA5, gap);
        send(a, gap);
        send(n, gap);
        foreach (d[i]) begin
            exp_q.push_back({3'b0, p, d[i]});
            s = s + d[i];
            p = p + 5'd1;
            send(d[i], gap);
        end
        s = 8'h00 - s;
        if (bad_sum) s = s + 8'h01;
        send(s, gap);
    endtask

    task automatic settle();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int nw;
        logic [7:0] basic[] = '{8'hA2, 8'h3F, 8'h00};
        logic [7:0] wrapd[] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] syncd[] = '{8'hA5, 8'hA5};

        rst_ = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu", {31'b0, cpu_rst_}, 32'd0);
        chk("rst_wr", {31'b0, mem_write}, 32'd0);
        chk("rst_addr_data", {19'b0, mem_addr, mem_data}, 32'd0);
        chk("rst_flags", {29'b0, busy, done, err}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        rst_ = 1'b1;
        #1;
        chk("ready", {31'b0, in_ready}, 32'd1);

        // junk before SYNC is dropped
        send(8'h42, 0);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // basic load
        d0 = done_cnt;
        nw = wcyc.size();
        frame(8'h00, 8'h03, basic, 1'b0, 1'b1, 0);
        settle();
        chk("basic_done", 32'(done_cnt - d0), 32'd1);
        chk("basic_cpu", {31'b0, cpu_rst_}, 32'd1);
        chk("basic_err", {31'b0, err}, 32'd0);
        chk("basic_consec", 32'(wcyc[nw + 2] - wcyc[nw]), 32'd2);
        chk("basic_q", 32'(exp_q.size()), 32'd0);

        // reload with gapped valid, SYNC bytes as data
        send(8'hA5, 1);
        chk("reload_cpu", {31'b0, cpu_rst_}, 32'd0);
        chk("reload_busy", {31'b0, busy}, 32'd1);
        d0 = done_cnt;
        frame(8'h00, 8'h02, syncd, 1'b0, 1'b0, 1);
        settle();
        chk("reload_done", 32'(done_cnt - d0), 32'd1);
        chk("reload_cpu2", {31'b0, cpu_rst_}, 32'd1);

        // wrap-around
        d0 = done_cnt;
        frame(8'h1E, 8'h04, wrapd, 1'b0, 1'b1, 0);
        settle();
        chk("wrap_done", 32'(done_cnt - d0), 32'd1);
        chk("wrap_q", 32'(exp_q.size()), 32'd0);

        // bad checksum
        d0 = done_cnt;
        frame(8'h00, 8'h03, basic, 1'b1, 1'b1, 0);
        settle();
        chk("bad_done", 32'(done_cnt - d0), 32'd0);
        chk("bad_err", {31'b0, err}, 32'd1);
        chk("bad_cpu", {31'b0, cpu_rst_}, 32'd0);
        send(8'h77, 0);
        chk("bad_sticky", {31'b0, err}, 32'd1);
        d0 = done_cnt;
        frame(8'h00, 8'h03, basic, 1'b0, 1'b1, 0);
        settle();
        chk("recov_done", 32'(done_cnt - d0), 32'd1);
        chk("recov_err", {31'b0, err}, 32'd0);
        chk("recov_cpu", {31'b0, cpu_rst_}, 32'd1);

        // bad headers: count 0, then address out of range
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("cnt0_err", {31'b0, err}, 32'd1);
        chk("cnt0_busy", {31'b0, busy}, 32'd0);
        send(8'hA5, 0);
        chk("cnt0_clear", {31'b0, err}, 32'd0);
        send(8'h20, 0);
        chk("addr_err", {31'b0, err}, 32'd1);
        send(8'hA5, 0);
        chk("addr_clear", {31'b0, err}, 32'd0);
        send(8'h00, 0);
        send(8'h21, 0);
        chk("cnt33_err", {31'b0, err}, 32'd1);
        settle();
        chk("hdr_q", 32'(exp_q.size()), 32'd0);

        // reset mid-frame after the second data byte
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h03, 0);
        exp_q.push_back({3'b0, 5'd0, 8'hA2});
        send(8'hA2, 0);
        exp_q.push_back({3'b0, 5'd1, 8'h3F});
        send(8'h3F, 0);
        @(negedge clk);
        #1;
        rst_ = 1'b0;
        #1;
        chk("mid_wr", {31'b0, mem_write}, 32'd0);
        chk("mid_flags", {28'b0, cpu_rst_, busy, done, err}, 32'd0);
        chk("mid_addr_data", {19'b0, mem_addr, mem_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        send(8'h00, 0);
        send(8'h1C, 0);
        settle();
        chk("mid_ignored", {30'b0, busy, err}, 32'd0);
        chk("mid_q", 32'(exp_q.size()), 32'd0);
        d0 = done_cnt;
        frame(8'h00, 8'h03, basic, 1'b0, 1'b1, 0);
        settle();
        chk("after_rst_done", 32'(done_cnt - d0), 32'd1);
        chk("after_rst_cpu", {31'b0, cpu_rst_}, 32'd1);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
